// File: rtl/fetch_pkg.sv
// Shared defaults and FSM encoding for the instruction fetch unit.
package fetch_pkg;

  localparam int AW_DEFAULT     = 12;
  localparam int IW_DEFAULT     = 19;
  localparam int QDEPTH_DEFAULT = 2;

  typedef enum logic {
    FETCH   = 1'b0,
    DISCARD = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of {instruction, pc} pairs with flush; head is exposed combinationally.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int AW    = AW_DEFAULT,
  parameter int IW    = IW_DEFAULT,
  parameter int DEPTH = QDEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [IW-1:0]            push_inst,
  input  logic [AW-1:0]            push_pc,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic [IW-1:0]            head_inst,
  output logic [AW-1:0]            head_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [IW-1:0] inst_mem [DEPTH];
  logic [AW-1:0] pc_mem   [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Guards keep the pointers sane even if a caller pushes into a full queue.
  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);

  assign head_inst = inst_mem[rd_ptr];
  assign head_pc   = pc_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      inst_mem[wr_ptr] <= push_inst;
      pc_mem[wr_ptr]   <= push_pc;
    end
  end

  // Flush wins over push and pop: everything in flight is thrown away.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: drives a single-outstanding memory read and feeds decode
// through a small queue; redirects flush and may leave one stale read to drain.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int AW     = AW_DEFAULT,
  parameter int IW     = IW_DEFAULT,
  parameter int QDEPTH = QDEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect_valid,
  input  logic [AW-1:0]            redirect_addr,
  output logic                     mem_req,
  output logic [AW-1:0]            mem_addr,
  input  logic                     mem_ack,
  input  logic [IW-1:0]            mem_rdata,
  output logic                     inst_valid,
  output logic [IW-1:0]            inst,
  output logic [AW-1:0]            inst_pc,
  input  logic                     inst_ready,
  output logic                     dbg_state,
  output logic [$clog2(QDEPTH):0]  dbg_count
);

  // Handshakes: memory read completes in the cycle mem_req&mem_ack, and
  // mem_req/mem_addr do not change until then; decode takes the head in the
  // cycle inst_valid&inst_ready, and the head is stable until that cycle.

  localparam int CW = $clog2(QDEPTH) + 1;

  fetch_state_t   state;
  fetch_state_t   state_n;
  logic [AW-1:0]  fpc;
  logic [AW-1:0]  hold_addr;
  logic [CW-1:0]  count;
  logic           q_full;
  logic           push;
  logic           pop;

  assign q_full     = (count == CW'(QDEPTH));
  assign inst_valid = (count != '0);
  assign pop        = inst_valid && inst_ready;
  assign push       = (state == FETCH) && mem_req && mem_ack && !redirect_valid;
  assign dbg_state  = state;
  assign dbg_count  = count;

  always_comb begin
    mem_req  = 1'b0;
    mem_addr = fpc;
    state_n  = state;
    case (state)
      FETCH: begin
        mem_req = !q_full;
        if (redirect_valid && mem_req && !mem_ack) state_n = DISCARD;
      end
      DISCARD: begin
        // The abandoned read must finish at its original address.
        mem_req  = 1'b1;
        mem_addr = hold_addr;
        if (mem_ack) state_n = FETCH;
      end
      default: state_n = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      fpc       <= '0;
      hold_addr <= '0;
    end else begin
      state <= state_n;
      if (state == FETCH && state_n == DISCARD) hold_addr <= fpc;
      if (redirect_valid)  fpc <= redirect_addr;
      else if (push)       fpc <= fpc + 1'b1;
    end
  end

  fetch_queue #(
    .AW    (AW),
    .IW    (IW),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_inst (mem_rdata),
    .push_pc   (fpc),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (count),
    .head_inst (inst),
    .head_pc   (inst_pc)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: inputs change and outputs are checked on the
// falling edge, so each negedge marks one cycle of the design.
module tb_fetch_unit;

  localparam int AW = 12;
  localparam int IW = 19;

  logic          clk = 1'b0;
  logic          rst;
  logic          redirect_valid;
  logic [AW-1:0] redirect_addr;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [IW-1:0] mem_rdata;
  logic          inst_valid;
  logic [IW-1:0] inst;
  logic [AW-1:0] inst_pc;
  logic          inst_ready;
  logic          dbg_state;
  logic [1:0]    dbg_count;

  int checks   = 0;
  int failures = 0;

  // clock / reset
  always #5 clk = ~clk;

  fetch_unit #(.AW(AW), .IW(IW), .QDEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .dbg_state      (dbg_state),
    .dbg_count      (dbg_count)
  );

  // Memory model: each word tags its own address so ordering errors show up.
  function automatic logic [IW-1:0] word(input logic [AW-1:0] a);
    return {7'h55, a};
  endfunction

  assign mem_rdata = word(mem_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic drive(input logic ack, input logic rdy, input logic redir, input logic [AW-1:0] raddr);
    mem_ack        = ack;
    inst_ready     = rdy;
    redirect_valid = redir;
    redirect_addr  = raddr;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0);

    // Streaming: one word per cycle, decode always ready.
    do_reset();
    check("rst_valid",  inst_valid, 0);
    check("rst_req",    mem_req,    1);
    check("rst_addr",   mem_addr,   0);
    check("rst_count",  dbg_count,  0);
    check("rst_state",  dbg_state,  0);
    drive(1'b1, 1'b1, 1'b0, '0);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      check("stream_valid", inst_valid, 1);
      check("stream_pc",    inst_pc,    k);
      check("stream_inst",  inst,       {7'h55, 12'(k)});
    end

    // Back-pressure: queue fills to 2, request drops, nothing lost.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, '0);
    repeat (6) next_cycle();
    check("full_count", dbg_count, 2);
    check("full_req",   mem_req,   0);
    check("full_head",  inst_pc,   0);
    drive(1'b1, 1'b1, 1'b0, '0);
    next_cycle();
    check("drain_pc1",  inst_pc,   1);
    check("drain_req",  mem_req,   1);
    check("drain_cnt",  dbg_count, 1);
    next_cycle();
    check("drain_pc2",  inst_pc,   2);
    check("drain_inst", inst,      {7'h55, 12'd2});

    // Redirect with same-cycle ack (word dropped), then wrap 4094 -> 0.
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 12'd4094);
    next_cycle();
    check("rdack_valid", inst_valid, 0);
    check("rdack_state", dbg_state,  0);
    check("rdack_addr",  mem_addr,   4094);
    drive(1'b1, 1'b1, 1'b0, '0);
    next_cycle();
    check("wrap_pc0",   inst_pc,  4094);
    check("wrap_addr0", mem_addr, 4095);
    next_cycle();
    check("wrap_pc1",   inst_pc,  4095);
    check("wrap_addr1", mem_addr, 0);
    next_cycle();
    check("wrap_pc2",   inst_pc,  0);

    // Redirect while the read is stalled: drain the old read, then 0x200.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, '0);
    next_cycle();
    check("dis_pre_addr", mem_addr, 1);
    drive(1'b0, 1'b0, 1'b1, 12'h200);
    next_cycle();
    check("dis_state", dbg_state,  1);
    check("dis_req",   mem_req,    1);
    check("dis_addr",  mem_addr,   1);
    check("dis_valid", inst_valid, 0);
    drive(1'b0, 1'b0, 1'b0, '0);
    next_cycle();
    next_cycle();
    check("dis_hold_addr",  mem_addr,  1);
    check("dis_hold_state", dbg_state, 1);
    drive(1'b1, 1'b0, 1'b0, '0);
    next_cycle();
    check("dis_exit_state", dbg_state,  0);
    check("dis_exit_addr",  mem_addr,   12'h200);
    check("dis_exit_valid", inst_valid, 0);
    drive(1'b1, 1'b1, 1'b0, '0);
    next_cycle();
    check("dis_new_pc",   inst_pc, 12'h200);
    check("dis_new_inst", inst,    {7'h55, 12'h200});

    // Redirect together with ack and pop.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, '0);
    next_cycle();
    check("rp_head_valid", inst_valid, 1);
    check("rp_head_pc",    inst_pc,    0);
    drive(1'b1, 1'b1, 1'b1, 12'h050);
    next_cycle();
    check("rp_valid", inst_valid, 0);
    check("rp_addr",  mem_addr,   12'h050);
    check("rp_state", dbg_state,  0);
    drive(1'b1, 1'b0, 1'b0, '0);
    next_cycle();
    check("rp_new_pc", inst_pc, 12'h050);

    // Second redirect while draining takes the newest target.
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 12'h100);
    next_cycle();
    check("rr_state", dbg_state, 1);
    drive(1'b0, 1'b0, 1'b1, 12'h3AB);
    next_cycle();
    check("rr_state2", dbg_state, 1);
    check("rr_addr",   mem_addr,  0);
    drive(1'b1, 1'b0, 1'b0, '0);
    next_cycle();
    check("rr_exit_addr", mem_addr,  12'h3AB);
    check("rr_exit_cnt",  dbg_count, 0);

    // Reset in the middle of a stalled request.
    do_reset();
    drive(1'b1, 1'b1, 1'b0, '0);
    next_cycle();
    next_cycle();
    check("mr_addr_pre", mem_addr, 2);
    drive(1'b0, 1'b0, 1'b0, '0);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    check("mr_addr",  mem_addr,   0);
    check("mr_count", dbg_count,  0);
    check("mr_valid", inst_valid, 0);
    next_cycle();
    check("mr_count2", dbg_count, 0);
    check("mr_req",    mem_req,   1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
